// File: rtl/alu_serial_if.sv
// Operand/command and result/status bundle between a requester and alu_serial.
interface alu_serial_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [2:0]       Op;
    logic [WIDTH-1:0] O;
    logic             Z;
    logic             P;
    logic             Cout;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Cin, Op,
        input  O, Z, P, Cout, busy, done
    );

    modport slave (
        input  start, A, B, Cin, Op,
        output O, Z, P, Cout, busy, done
    );
endinterface

// File: rtl/alu_serial.sv
// Bit-serial ALU: one 1-bit slice evaluated per clock, LSB first, with the
// carry held in a flop between bits. Results and flags are registered.
module alu_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    alu_serial_if.slave   bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             z_q, z_d;
    logic             p_q, p_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_bit;
    logic             b_bit;
    logic             b_eff;
    logic             res_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] part_new;
    logic             last_bit;

    // 1-bit ALU slice on the bit currently addressed by the counter
    always_comb begin
        a_bit     = a_q[cnt_q];
        b_bit     = b_q[cnt_q];
        b_eff     = (op_q == OP_SUB) ? ~b_bit : b_bit;
        res_bit   = 1'b0;
        carry_nxt = 1'b0;
        case (op_q)
            OP_AND:  res_bit = a_bit & b_bit;
            OP_OR:   res_bit = a_bit | b_bit;
            OP_XOR:  res_bit = a_bit ^ b_bit;
            OP_NOR:  res_bit = ~(a_bit | b_bit);
            OP_ADD, OP_SUB: begin
                res_bit   = a_bit ^ b_eff ^ carry_q;
                carry_nxt = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);
            end
            OP_PASS: res_bit = a_bit;
            OP_NOT:  res_bit = ~a_bit;
            default: res_bit = 1'b0;
        endcase
        part_new          = part_q;
        part_new[cnt_q]   = res_bit;
        last_bit          = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        part_d  = part_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        o_d     = o_q;
        z_d     = z_q;
        p_d     = p_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.Op;
                    // Only arithmetic ops consume the carry-in
                    carry_d = (bus.Op[2:1] == 2'b10) ? bus.Cin : 1'b0;
                    cnt_d   = '0;
                    part_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                part_d  = part_new;
                carry_d = carry_nxt;
                if (last_bit) begin
                    o_d     = part_new;
                    z_d     = (part_new == '0);
                    p_d     = ^part_new;
                    cout_d  = carry_nxt;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            o_q     <= '0;
            z_q     <= 1'b1;
            p_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            o_q     <= o_d;
            z_q     <= z_d;
            p_q     <= p_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.O    = o_q;
    assign bus.Z    = z_q;
    assign bus.P    = p_q;
    assign bus.Cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
